// File: rtl/ex_issue_stage.sv
// ex_issue_stage: decode/issue register feeding the one-hot ALU.
// Holds decoded operands under valid/ready; flush drops held and incoming ops.
module ex_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           inst,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] store_data,
  output logic [4:0]            rd,
  output logic                  rf_wen,
  output logic                  is_branch,
  output logic                  is_load,
  output logic                  is_store,
  output logic                  is_jump,
  output logic [2:0]            funct3_q,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic                  illegal
);

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_AND   = 2;
  localparam int OP_OR    = 3;
  localparam int OP_AUIPC = 4;
  localparam int OP_XOR   = 5;
  localparam int OP_SLT   = 6;
  localparam int OP_SLTU  = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;

  function automatic logic [OP_WIDTH-1:0] f3_op(input logic [2:0] f);
    logic [OP_WIDTH-1:0] o;
    o = '0;
    unique case (f)
      3'b000: o[OP_ADD]  = 1'b1;
      3'b001: o[OP_SLL]  = 1'b1;
      3'b010: o[OP_SLT]  = 1'b1;
      3'b011: o[OP_SLTU] = 1'b1;
      3'b100: o[OP_XOR]  = 1'b1;
      3'b101: o[OP_SRL]  = 1'b1;
      3'b110: o[OP_OR]   = 1'b1;
      3'b111: o[OP_AND]  = 1'b1;
    endcase
    return o;
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd_d;
  logic       f7_z;
  logic       f7_alt;
  logic       shift;

  assign opc    = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign rd_d   = inst[11:7];
  assign f7_z   = (f7 == 7'b0000000);
  assign f7_alt = (f7 == 7'b0100000);
  assign shift  = (f3 == 3'b001) || (f3 == 3'b101);

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u = {12'b0, inst[31:12]};
  assign shamt = {27'b0, inst[24:20]};

  logic is_op;
  logic is_opi;
  logic is_lui;
  logic is_auipc;
  logic is_ld;
  logic is_st;
  logic is_br;
  logic is_jal;
  logic is_jalr;

  assign is_op    = (opc == 7'b0110011);
  assign is_opi   = (opc == 7'b0010011);
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_ld    = (opc == 7'b0000011);
  assign is_st    = (opc == 7'b0100011);
  assign is_br    = (opc == 7'b1100011);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);

  logic [OP_WIDTH-1:0]   op_d;
  logic [DATA_WIDTH-1:0] a_d;
  logic [DATA_WIDTH-1:0] b_d;
  logic wen_d, br_d, ld_d, st_d, jp_d, ill_d;

  always_comb begin
    op_d  = '0;
    a_d   = '0;
    b_d   = '0;
    wen_d = 1'b0;
    br_d  = 1'b0;
    ld_d  = 1'b0;
    st_d  = 1'b0;
    jp_d  = 1'b0;
    ill_d = 1'b0;
    unique case (1'b1)
      is_op: begin
        a_d   = rs1_data;
        b_d   = rs2_data;
        wen_d = 1'b1;
        if (f7_z) op_d = f3_op(f3);
        else if (f7_alt && f3 == 3'b000) op_d[OP_SUB] = 1'b1;
        else if (f7_alt && f3 == 3'b101) op_d[OP_SRA] = 1'b1;
        else ill_d = 1'b1;
      end
      is_opi: begin
        a_d   = rs1_data;
        b_d   = shift ? shamt : imm_i;
        wen_d = 1'b1;
        if (!shift || f7_z) op_d = f3_op(f3);
        else if (f7_alt && f3 == 3'b101) op_d[OP_SRA] = 1'b1;
        else ill_d = 1'b1;
      end
      is_lui: begin
        op_d[OP_LUI] = 1'b1;
        b_d   = imm_u;
        wen_d = 1'b1;
      end
      is_auipc: begin
        op_d[OP_AUIPC] = 1'b1;
        a_d   = pc;
        b_d   = imm_u;
        wen_d = 1'b1;
      end
      is_ld: begin
        op_d[OP_ADD] = 1'b1;
        a_d   = rs1_data;
        b_d   = imm_i;
        ld_d  = 1'b1;
        wen_d = 1'b1;
      end
      is_st: begin
        op_d[OP_ADD] = 1'b1;
        a_d  = rs1_data;
        b_d  = imm_s;
        st_d = 1'b1;
      end
      is_br: begin
        a_d  = rs1_data;
        b_d  = rs2_data;
        br_d = 1'b1;
        unique case (f3[2:1])
          2'b00:   op_d[OP_SUB]  = 1'b1;
          2'b10:   op_d[OP_SLT]  = 1'b1;
          2'b11:   op_d[OP_SLTU] = 1'b1;
          default: ill_d = 1'b1;
        endcase
      end
      is_jal, is_jalr: begin
        op_d[OP_ADD] = 1'b1;
        a_d   = pc;
        b_d   = 32'd4;
        jp_d  = 1'b1;
        wen_d = 1'b1;
        if (is_jalr && f3 != 3'b000) ill_d = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
    // Illegal ops travel as a clean trap marker with no side effects.
    if (ill_d) begin
      op_d  = '0;
      a_d   = '0;
      b_d   = '0;
      wen_d = 1'b0;
      br_d  = 1'b0;
      ld_d  = 1'b0;
      st_d  = 1'b0;
      jp_d  = 1'b0;
    end
    if (rd_d == 5'd0) wen_d = 1'b0;
  end

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, sd_q, pc_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [4:0]            rd_q;
  logic [2:0]            f3_q;
  logic wen_q, br_q, ld_q, st_q, jp_q, ill_q;
  logic cap;

  assign in_ready = !flush && (!valid_q || out_ready);
  assign cap      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sd_q    <= '0;
      pc_q    <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      wen_q   <= 1'b0;
      br_q    <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      jp_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (cap) begin
      valid_q <= 1'b1;
      a_q     <= a_d;
      b_q     <= b_d;
      sd_q    <= rs2_data;
      pc_q    <= pc;
      op_q    <= op_d;
      rd_q    <= rd_d;
      f3_q    <= f3;
      wen_q   <= wen_d;
      br_q    <= br_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      jp_q    <= jp_d;
      ill_q   <= ill_d;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign alu_A      = a_q;
  assign alu_B      = b_q;
  assign alu_op     = op_q;
  assign store_data = sd_q;
  assign rd         = rd_q;
  assign rf_wen     = wen_q;
  assign is_branch  = br_q;
  assign is_load    = ld_q;
  assign is_store   = st_q;
  assign is_jump    = jp_q;
  assign funct3_q   = f3_q;
  assign out_pc     = pc_q;
  assign illegal    = ill_q;

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- Decode/issue pipeline register that sits directly upstream of the 12-bit one-hot ALU.
- Takes a fetched instruction, its PC and the two register-file read values.
- Decodes the ALU operation and selects the operands, then holds the registered ALU inputs stable under a valid/ready handshake until the execute stage consumes them.
- Supports a single-cycle flush for branch redirect.

Parameters:
DATA_WIDTH, 32, operand/PC width (only 32 supported)
OP_WIDTH, 12, one-hot ALU op width; bit map fixed: 0 add, 1 sub, 2 and, 3 or, 4 auipc, 5 xor, 6 slt, 7 sltu, 8 sll, 9 srl, 10 sra, 11 lui

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard held and incoming instruction
in_valid  in  1  upstream offers inst/pc/rs1_data/rs2_data
in_ready  out  1  stage can accept this cycle
inst  in  32  instruction word
pc  in  32  instruction address
rs1_data  in  32  register file read port 1
rs2_data  in  32  register file read port 2
out_valid  out  1  registered outputs hold a valid op
out_ready  in  1  execute stage consumes this cycle
alu_A  out  32  ALU operand A
alu_B  out  32  ALU operand B
alu_op  out  12  one-hot ALU op (all zero when illegal)
store_data  out  32  rs2_data captured for stores
rd  out  5  destination register
rf_wen  out  1  writeback enable
is_branch, is_load, is_store, is_jump  out  1 each  class flags
funct3_q  out  3  captured funct3 (branch condition select downstream)
out_pc  out  32  captured PC
illegal  out  1  unsupported encoding

Behaviour:
- Reset: all outputs registered and cleared to 0 (out_valid=0, alu_op=0, illegal=0). in_ready=1 after reset.
- in_ready = !flush && (!out_valid || out_ready). It is purely combinational and never depends on in_valid.
- Capture: on in_valid && in_ready, all outputs load decoded values and out_valid=1 next cycle. Latency is 1 cycle.
- Consume without refill: out_valid && out_ready && !capture causes out_valid to go to 0. Data outputs hold their last value.
- Stall: out_valid && !out_ready keeps every output bit-stable.
- Simultaneous consume and capture: new op loaded, out_valid stays 1, no bubble. Full throughput is one op/cycle.
- flush: out_valid goes to 0 next cycle. in_ready=0 that cycle, so the input is dropped. flush overrides capture.
- rst has priority over flush and capture.
- Immediates:
  - I = sext(inst[31:20])
  - S = sext({inst[31:25], inst[11:7]})
  - U-field = {12'b0, inst[31:12]}. The ALU itself shifts U left by 12.
- Decode by opcode inst[6:0]:
  - 0110011 OP: A=rs1, B=rs2.
    - f3 000: f7 0000000 gives add, 0100000 gives sub.
    - 001 sll, 010 slt, 011 sltu, 100 xor.
    - 101: f7 0000000 gives srl, 0100000 gives sra.
    - 110 or, 111 and.
    - Any other f7 is illegal.
    - rf_wen=1.
  - 0010011 OP-IMM: A=rs1, B=I. Same f3 map, no sub.
    - Shifts use B={27'b0, inst[24:20]}.
    - srai requires inst[31:25]=0100000. slli/srli require 0000000; otherwise illegal.
    - rf_wen=1.
  - 0110111 LUI: lui, A=0, B=U-field, rf_wen=1.
  - 0010111 AUIPC: auipc, A=pc, B=U-field, rf_wen=1.
  - 0000011 LOAD: add, A=rs1, B=I, is_load=1, rf_wen=1.
  - 0100011 STORE: add, A=rs1, B=S, is_store=1, store_data=rs2, rf_wen=0.
  - 1100011 BRANCH: A=rs1, B=rs2, is_branch=1, rf_wen=0.
    - f3 000/001: sub. 100/101: slt. 110/111: sltu. 010/011: illegal.
  - 1101111 JAL / 1100111 JALR (f3=000 only): add, A=pc, B=4, is_jump=1, rf_wen=1.
  - Anything else: illegal=1, alu_op=0, rf_wen=0, all class flags 0. out_valid still asserts so the trap is seen downstream.
- rd=inst[11:7]. rf_wen is forced to 0 when rd==0.
- alu_op is exactly one-hot for every legal op and all-zero for illegal ops; no other patterns occur.

Test Plan:
1. Reset then idle -> out_valid=0, alu_op=0, in_ready=1. Present `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_op=0x001, A=5, B=7, rd=3, rf_wen=1.
2. Decode sweep:
   - `sub` (0x402081B3) -> 0x002.
   - `srai x1,x1,3` (0x4030D093) -> 0x400, B=3.
   - `lui x5,0x12345` (0x123452B7) -> 0x800, A=0, B=0x00012345.
   - `auipc` with pc=0x100 -> 0x010, A=0x100.
   - `addi x1,x0,-1` (0xFFF00093) -> B=0xFFFFFFFF.
3. Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs bit-stable. Release -> back-to-back ops with no bubble, out_valid continuously 1.
4. Branch/store:
   - `bltu` -> alu_op=0x080, is_branch=1, rf_wen=0.
   - `sw` (0x0020A223), rs2=0xDEADBEEF -> B=4, store_data=0xDEADBEEF.
   - `add x0,x1,x2` -> rf_wen=0.
5. Illegal: opcode 0x7F, and OP with f7=0000001 -> illegal=1, alu_op=0, out_valid=1.
6. flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0, input dropped. rst asserted mid-stall -> out_valid=0 next cycle, in_ready=1.
